xbar_slave_regs: RTL
====================

# xbar_slave_regs

Slave-side endpoint that sits directly downstream of one `top_cross_bar` slave port. It accepts single-beat read and write requests routed by the crossbar and stores data in a small register bank. Each access completes after a programmable number of wait states, and read data is returned through a held response handshake. One instance is placed per crossbar slave port. The crossbar has already consumed the slave-select bits addr[AW-1:AW-2].

## Interface
- DW, 32, data width
- AW, 32, address width
- DEPTH, 16, number of DW-bit registers; power of two, 2..256
- LATENCY, 2, wait states between request acceptance and ack_o; 0..15

- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- req_i  in  1  request valid from the crossbar slave port
- cmd_i  in  1  1 = write, 0 = read
- addr_i  in  AW  byte address; word index = addr_i[$clog2(DEPTH)+1:2]; other bits are ignored
- wdata_i  in  DW  write data
- ack_o  out  1  one-cycle pulse: request accepted and executed
- resp_o  out  1  read response valid; held until it is acknowledged
- rdata_o  out  DW  read data; valid while resp_o=1
- resp_ack_i  in  1  requester accepts the read response

## Operation
- States:
  - IDLE: wait for a request.
  - WAIT: count LATENCY wait states.
  - ACK: execute the access and pulse ack_o.
  - GAP: ignore req_i for one cycle.
  - RESP: hold the read response.
- IDLE, req_i=1 at a rising edge:
  - Latch cmd_i, the word index and wdata_i; load wait counter = LATENCY.
  - Go to WAIT, or directly to ACK if LATENCY=0.
- Request inputs after acceptance are don't-care. Only the latched copy is used.
- WAIT: the counter decrements each cycle; leave for ACK when it reaches 1.
- ACK (ack_o=1 for exactly one cycle):
  - Write: regs[idx] <= latched wdata at the end of the ACK cycle; next state GAP.
  - Read: rdata_o <= regs[idx] at the end of the ACK cycle; next state RESP.
- GAP: req_i is ignored. This covers the requester dropping req one cycle after seeing ack_o. Next state is IDLE.
- RESP:
  - resp_o=1 and rdata_o is stable.
  - Go to IDLE at the first edge where resp_ack_i=1.
  - req_i is ignored in this state.
- Read-after-write to the same index returns the new value, because the write commits in ACK before any later read.
- resp_ack_i outside RESP is ignored.
- Address bits above the index are ignored, so any index aliases across the upper address bits and out-of-range access is impossible.
- Wait counter is 4 bits; it never wraps because it is loaded only in IDLE.

## Timing
- Reset (asynchronous, reset_n_i=0):
  - State IDLE; ack_o=0, resp_o=0, rdata_o=0.
  - All regs=0; wait counter=0.
  - Takes effect immediately.
- Reset mid-access: the access is abandoned and no write commits. Reset during RESP drops resp_o at once.
- Leaving reset: the first edge with reset_n_i=1 may accept a request.
- Request accepted at edge E0 → ack_o high during cycle E0+LATENCY+1, i.e. between edges E0+LATENCY and E0+LATENCY+1 (LATENCY=0: the cycle right after E0).
- Read: resp_o rises one cycle after the ack_o cycle. Minimum read turnaround is LATENCY+2 cycles plus the resp_ack_i wait.
- Write: earliest next acceptance is 2 cycles after the ack_o cycle (ACK→GAP→IDLE).
- Requester rule: keep req_i and the payload stable until ack_o, and deassert req_i no later than the cycle after ack_o. A req_i still high in IDLE starts a new access.
- resp_ack_i held high continuously: RESP lasts exactly one cycle.

## Test plan
- Reset and readback:
  - Stimulus: hold reset_n_i=0; release; read index 5.
  - Required: ack_o, resp_o and rdata_o are 0 during reset; the read returns rdata_o=0.
- Write then read, LATENCY=2:
  - Stimulus: write 0x637 to addr 0x14 (index 5); then read addr 0x14 with resp_ack_i=1.
  - Required: ack_o arrives 3 cycles after acceptance; rdata_o=0x637 with resp_o high for exactly one cycle.
- Held response:
  - Stimulus: read index 5 with resp_ack_i=0 for 7 cycles.
  - Required: resp_o and rdata_o=0x637 are stable for all 7 cycles; a req_i pulse during RESP is ignored (no ack_o); IDLE follows the cycle after resp_ack_i=1.
- Late req drop:
  - Stimulus: write 0x5682 to index 2 and keep req_i high for one cycle after ack_o.
  - Required: exactly one ack_o pulse and no second write.
- Back-to-back with aliasing, LATENCY=0:
  - Stimulus: write 0x8901 to addr 0xC000_0008, then read addr 0x0000_0008.
  - Required: ack_o the cycle after acceptance; read returns 0x8901.
- Reset mid-access:
  - Stimulus: accept a write of 0x1212 to index 3; assert reset_n_i=0 during WAIT; release; read index 3.
  - Required: ack_o is never asserted for the aborted write; the read returns 0.

Source files
------------

// File: rtl/xbar_slave_regs.sv
// xbar_slave_regs: crossbar slave endpoint with a wait-stated register bank and held read response
module xbar_slave_regs #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          req_i,
  input  logic          cmd_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          ack_o,
  output logic          resp_o,
  output logic [DW-1:0] rdata_o,
  input  logic          resp_ack_i
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);
  typedef enum logic [2:0] {IDLE, WAIT, ACK, GAP, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          cmd_q, cmd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          resp_q, resp_d;
  logic [DW-1:0] regs_q [DEPTH];
  logic [DW-1:0] regs_d [DEPTH];
  logic          unused_addr;
  assign unused_addr = ^{addr_i[AW-1:IW+2], addr_i[1:0]};
  assign ack_o   = ack_q;
  assign resp_o  = resp_q;
  assign rdata_o = rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: if (req_i) begin
        state_d = (LATENCY == 0) ? ACK : WAIT;
        cnt_d   = LAT;
        cmd_d   = cmd_i;
        idx_d   = addr_i[IW+1:2];
        wdata_d = wdata_i;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? ACK : WAIT;
      end
      ACK: begin
        state_d = cmd_q ? GAP : RESP;
        if (cmd_q) regs_d[idx_q] = wdata_q;
        else rdata_d = regs_q[idx_q];
      end
      GAP:     state_d = IDLE;
      RESP:    state_d = resp_ack_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    ack_d  = (state_d == ACK);
    resp_d = (state_d == RESP);
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
      regs_q  <= regs_d;
    end
  end
endmodule
